// File: rtl/ysyx_23060191_idu.sv
// ---------------------------------------------------------------------------
// ysyx_23060191_idu -- instruction decode stage
//
// Takes an instruction/pc pair from the IFU over a valid/ready handshake. It
// drives the register-file read addresses straight from the instruction and
// decodes against the same-cycle read data. The result is captured as one
// ALU request (op1, op2, ctr, rd, wen, illegal), which is offered to the EXU
// over a second valid/ready handshake. The stage holds one entry and supports
// stall (out_ready low) and flush.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    IFU handshake; in_ready = !flush & (!out_valid | out_ready)
//   inst, pc             instruction word and its address
//   rs1_addr/rs2_addr    register-file read addresses (combinational from inst)
//   rs1_data/rs2_data    register-file read data (same cycle)
//   flush                drop the held request; blocks acceptance this cycle
//   out_valid/out_ready  EXU handshake
//   op1, op2, ctr        ALU operands and operation
//   rd, wen              destination register and its write enable
//   illegal              held instruction could not be decoded
// ---------------------------------------------------------------------------
package ysyx_23060191_idu_pkg;
  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_SLL = 3'd2,
    ALU_SLT = 3'd3,
    ALU_LUI = 3'd4
  } alu_ctr_e;
endpackage

module ysyx_23060191_idu
  import ysyx_23060191_idu_pkg::*;
#(
  parameter int CPU_WIDTH = 64,
  parameter int REG_AW    = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          inst,
  input  logic [CPU_WIDTH-1:0] pc,
  output logic [REG_AW-1:0]    rs1_addr,
  output logic [REG_AW-1:0]    rs2_addr,
  input  logic [CPU_WIDTH-1:0] rs1_data,
  input  logic [CPU_WIDTH-1:0] rs2_data,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CPU_WIDTH-1:0] op1,
  output logic [CPU_WIDTH-1:0] op2,
  output logic [2:0]           ctr,
  output logic [REG_AW-1:0]    rd,
  output logic                 wen,
  output logic                 illegal
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  logic [6:0]           opcode;
  logic [2:0]           funct3;
  logic [6:0]           funct7;
  logic [CPU_WIDTH-1:0] i_imm;
  logic [CPU_WIDTH-1:0] u_imm;
  logic [CPU_WIDTH-1:0] dec_op1;
  logic [CPU_WIDTH-1:0] dec_op2;
  alu_ctr_e             dec_ctr;
  logic                 dec_legal;
  logic [REG_AW-1:0]    dec_rd;
  logic                 accept;
  alu_ctr_e             ctr_q;

  assign opcode   = inst[6:0];
  assign funct3   = inst[14:12];
  assign funct7   = inst[31:25];
  assign rs1_addr = REG_AW'(inst[19:15]);
  assign rs2_addr = REG_AW'(inst[24:20]);
  assign dec_rd   = REG_AW'(inst[11:7]);

  // A size cast of a signed expression sign-extends to CPU_WIDTH.
  assign i_imm = CPU_WIDTH'($signed(inst[31:20]));
  assign u_imm = CPU_WIDTH'($signed({inst[31:12], 12'h000}));

  // Flush wins over everything: no new instruction enters while the held
  // request is being discarded.
  assign in_ready = !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // The ALU answers 1 when op1 > op2, so set-less-than swaps its operands.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a value unassigned and no latch is inferred.
    dec_op1   = '0;
    dec_op2   = '0;
    dec_ctr   = ALU_ADD;
    dec_legal = 1'b1;
    case (opcode)
      OPC_LUI: begin
        dec_op2 = u_imm;
        dec_ctr = ALU_LUI;
      end
      OPC_AUIPC: begin
        dec_op1 = pc;
        dec_op2 = u_imm;
      end
      OPC_OP_IMM: begin
        case (funct3)
          3'b000: begin
            dec_op1 = rs1_data;
            dec_op2 = i_imm;
          end
          3'b010: begin
            dec_op1 = i_imm;
            dec_op2 = rs1_data;
            dec_ctr = ALU_SLT;
          end
          3'b001: begin
            // 64-bit shift: the top six bits of the immediate must be zero.
            if (inst[31:26] == 6'b0) begin
              dec_op1 = rs1_data;
              dec_op2 = CPU_WIDTH'(inst[25:20]);
              dec_ctr = ALU_SLL;
            end else begin
              dec_legal = 1'b0;
            end
          end
          default: dec_legal = 1'b0;
        endcase
      end
      OPC_OP: begin
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000: begin
              dec_op1 = rs1_data;
              dec_op2 = rs2_data;
            end
            3'b001: begin
              dec_op1 = rs1_data;
              dec_op2 = CPU_WIDTH'(rs2_data[5:0]);
              dec_ctr = ALU_SLL;
            end
            3'b010: begin
              dec_op1 = rs2_data;
              dec_op2 = rs1_data;
              dec_ctr = ALU_SLT;
            end
            default: dec_legal = 1'b0;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          dec_op1 = rs1_data;
          dec_op2 = rs2_data;
          dec_ctr = ALU_SUB;
        end else begin
          dec_legal = 1'b0;
        end
      end
      default: dec_legal = 1'b0;
    endcase
    // An undecodable word becomes a harmless no-op request.
    if (!dec_legal) begin
      dec_op1 = '0;
      dec_op2 = '0;
      dec_ctr = ALU_ADD;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: reset is synchronous; it takes effect only at a clock edge.
      out_valid <= 1'b0;
      op1       <= '0;
      op2       <= '0;
      ctr_q     <= ALU_ADD;
      rd        <= '0;
      wen       <= 1'b0;
      illegal   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      op1       <= dec_op1;
      op2       <= dec_op2;
      ctr_q     <= dec_ctr;
      rd        <= dec_rd;
      wen       <= dec_legal && (dec_rd != '0);
      illegal   <= !dec_legal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign ctr = ctr_q;

endmodule

// File: tb/tb_ysyx_23060191_idu.sv
// ---------------------------------------------------------------------------
// tb_ysyx_23060191_idu -- self-checking bench for the decode stage.
// Directed scenarios check the documented examples against constants; a
// randomized run checks every cycle against a transaction-level model that
// decodes instructions by their mnemonic rules.
// ---------------------------------------------------------------------------
module tb_ysyx_23060191_idu;
  import ysyx_23060191_idu_pkg::*;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] inst;
  logic [63:0] pc, rs1_data, rs2_data, op1, op2;
  logic [4:0]  rs1_addr, rs2_addr, rd;
  logic [2:0]  ctr;
  logic        wen, illegal;

  logic [63:0] regs [32];
  assign rs1_data = regs[rs1_addr];
  assign rs2_data = regs[rs2_addr];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ysyx_23060191_idu #(.CPU_WIDTH(64), .REG_AW(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .inst(inst), .pc(pc), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .op1(op1), .op2(op2),
    .ctr(ctr), .rd(rd), .wen(wen), .illegal(illegal)
  );

  typedef struct {
    logic [63:0] op1;
    logic [63:0] op2;
    logic [2:0]  ctr;
    logic [4:0]  rd;
    logic        wen;
    logic        ill;
  } req_t;

  // Reference decoder: identify the mnemonic, then apply its operand rule.
  function automatic req_t ref_decode(input logic [31:0] i, input logic [63:0] p);
    req_t        e;
    logic [63:0] a, b, iimm, uimm;
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    opc  = i[6:0];
    f3   = i[14:12];
    f7   = i[31:25];
    a    = regs[i[19:15]];
    b    = regs[i[24:20]];
    iimm = {{52{i[31]}}, i[31:20]};
    uimm = {{32{i[31]}}, i[31:12], 12'h000};
    e.op1 = 64'd0; e.op2 = 64'd0; e.ctr = ALU_ADD; e.ill = 1'b0; e.rd = i[11:7];
    if (opc == 7'h37)                                   begin e.op2 = uimm; e.ctr = ALU_LUI; end
    else if (opc == 7'h17)                              begin e.op1 = p; e.op2 = uimm; end
    else if (opc == 7'h13 && f3 == 3'd0)                begin e.op1 = a; e.op2 = iimm; end
    else if (opc == 7'h13 && f3 == 3'd2)                begin e.op1 = iimm; e.op2 = a; e.ctr = ALU_SLT; end
    else if (opc == 7'h13 && f3 == 3'd1 && i[31:26] == 6'd0)
                                                        begin e.op1 = a; e.op2 = 64'(i[25:20]); e.ctr = ALU_SLL; end
    else if (opc == 7'h33 && f7 == 7'h00 && f3 == 3'd0) begin e.op1 = a; e.op2 = b; end
    else if (opc == 7'h33 && f7 == 7'h20 && f3 == 3'd0) begin e.op1 = a; e.op2 = b; e.ctr = ALU_SUB; end
    else if (opc == 7'h33 && f7 == 7'h00 && f3 == 3'd1) begin e.op1 = a; e.op2 = b % 64; e.ctr = ALU_SLL; end
    else if (opc == 7'h33 && f7 == 7'h00 && f3 == 3'd2) begin e.op1 = b; e.op2 = a; e.ctr = ALU_SLT; end
    else e.ill = 1'b1;
    e.wen = !e.ill && (e.rd != 5'd0);
    return e;
  endfunction

  function automatic logic [31:0] gen_inst();
    logic [31:0] r;
    logic [4:0]  d, s1, s2;
    r  = $urandom();
    d  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    s1 = 5'($urandom_range(0, 31));
    s2 = 5'($urandom_range(0, 31));
    case ($urandom_range(0, 9))
      0: return {r[31:12], d, 7'h37};
      1: return {r[31:12], d, 7'h17};
      2: return {r[31:20], s1, 3'd0, d, 7'h13};
      3: return {r[31:20], s1, 3'd2, d, 7'h13};
      4: return {6'd0, r[25:20], s1, 3'd1, d, 7'h13};
      5: return {7'h00, s2, s1, 3'd0, d, 7'h33};
      6: return {7'h20, s2, s1, 3'd0, d, 7'h33};
      7: return {7'h00, s2, s1, 3'd1, d, 7'h33};
      8: return {7'h00, s2, s1, 3'd2, d, 7'h33};
      default: return r;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    inst = 32'h0000_0013; pc = 64'h8000_0000;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    tick(); tick();
    rst = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
    total++; if (wen !== 1'b0) begin bad++; $display("FAIL reset_wen got=%0b want=0", wen); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b want=1", in_ready); end
    total++; if (op1 !== 64'd0 || op2 !== 64'd0) begin bad++; $display("FAIL reset_ops got=%h/%h want=0/0", op1, op2); end
    total++; if (ctr !== ALU_ADD || rd !== 5'd0 || illegal !== 1'b0) begin
      bad++; $display("FAIL reset_fields got ctr=%0d rd=%0d ill=%0b want 0/0/0", ctr, rd, illegal); end
  endtask

  task automatic test_addi();
    in_valid = 1'b1; inst = 32'h00A0_0093;
    tick();
    in_valid = 1'b0;
    #1;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL addi_valid got=%0b want=1", out_valid); end
    total++; if (op1 !== 64'd0 || op2 !== 64'd10) begin bad++; $display("FAIL addi_ops got=%h/%h want=0/a", op1, op2); end
    total++; if (ctr !== ALU_ADD || rd !== 5'd1 || wen !== 1'b1) begin
      bad++; $display("FAIL addi_fields got ctr=%0d rd=%0d wen=%0b want 0/1/1", ctr, rd, wen); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL addi_drain got=%0b want=0", out_valid); end
  endtask

  task automatic test_lui();
    in_valid = 1'b1; inst = 32'h1234_5037; pc = 64'hDEAD_BEEF_0000_1000;
    tick();
    in_valid = 1'b0;
    #1;
    total++; if (op1 !== 64'd0 || op2 !== 64'h0000_0000_1234_5000) begin
      bad++; $display("FAIL lui_ops got=%h/%h want=0/12345000", op1, op2); end
    total++; if (ctr !== ALU_LUI || wen !== 1'b0 || rd !== 5'd0) begin
      bad++; $display("FAIL lui_fields got ctr=%0d wen=%0b rd=%0d want 4/0/0", ctr, wen, rd); end
    tick();
  endtask

  task automatic test_stall();
    out_ready = 1'b0; in_valid = 1'b1; inst = 32'hFFF0_0293;  // addi x5,x0,-1
    tick();
    inst = 32'h0010_0313;                                    // addi x6,x0,1
    for (int k = 0; k < 3; k++) begin
      #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready[%0d] got=%0b want=0", k, in_ready); end
      total++; if (out_valid !== 1'b1 || op2 !== 64'hFFFF_FFFF_FFFF_FFFF || rd !== 5'd5) begin
        bad++; $display("FAIL stall_hold[%0d] got v=%0b op2=%h rd=%0d want 1/ffffffffffffffff/5", k, out_valid, op2, rd); end
      tick();
    end
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stall_release got=%0b want=1", in_ready); end
    tick();
    in_valid = 1'b0;
    #1;
    total++; if (out_valid !== 1'b1 || rd !== 5'd6 || op2 !== 64'd1) begin
      bad++; $display("FAIL stall_next got v=%0b rd=%0d op2=%h want 1/6/1", out_valid, rd, op2); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_drain got=%0b want=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    regs[1] = 64'd5; regs[2] = 64'd7;
    in_valid = 1'b1; inst = 32'h4020_8033;                   // sub x0,x1,x2
    tick();
    inst = 32'h0020_A1B3;                                    // slt x3,x1,x2
    #1;
    total++; if (op1 !== 64'd5 || op2 !== 64'd7 || ctr !== ALU_SUB || wen !== 1'b0) begin
      bad++; $display("FAIL sub got op1=%h op2=%h ctr=%0d wen=%0b want 5/7/1/0", op1, op2, ctr, wen); end
    tick();
    in_valid = 1'b0;
    #1;
    total++; if (out_valid !== 1'b1 || op1 !== 64'd7 || op2 !== 64'd5 || ctr !== ALU_SLT) begin
      bad++; $display("FAIL slt got v=%0b op1=%h op2=%h ctr=%0d want 1/7/5/3", out_valid, op1, op2, ctr); end
    total++; if (rd !== 5'd3 || wen !== 1'b1) begin bad++; $display("FAIL slt_rd got rd=%0d wen=%0b want 3/1", rd, wen); end
    tick();
  endtask

  task automatic test_flush_illegal();
    out_ready = 1'b0; in_valid = 1'b1; inst = 32'h00A0_0093;
    tick();
    flush = 1'b1; inst = 32'hFFFF_FFFF;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready got=%0b want=0", in_ready); end
    tick();
    flush = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%0b want=0", out_valid); end
    tick();
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    total++; if (out_valid !== 1'b1 || illegal !== 1'b1 || wen !== 1'b0) begin
      bad++; $display("FAIL illegal got v=%0b ill=%0b wen=%0b want 1/1/0", out_valid, illegal, wen); end
    total++; if (op1 !== 64'd0 || op2 !== 64'd0 || ctr !== ALU_ADD) begin
      bad++; $display("FAIL illegal_ops got op1=%h op2=%h ctr=%0d want 0/0/0", op1, op2, ctr); end
    tick();
  endtask

  task automatic test_rst_mid_stall();
    out_ready = 1'b0; in_valid = 1'b1; inst = 32'h00A0_0093;
    tick();
    in_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; out_ready = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0 || wen !== 1'b0 || rd !== 5'd0) begin
      bad++; $display("FAIL rst_stall got v=%0b wen=%0b rd=%0d want 0/0/0", out_valid, wen, rd); end
  endtask

  task automatic test_random();
    logic m_valid;
    req_t m_req;
    logic exp_ready;
    rst = 1'b1; idle_inputs();
    tick();
    rst = 1'b0;
    m_valid = 1'b0;
    m_req = ref_decode(32'h0, 64'h0);
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 199) == 0);
      flush     = ($urandom_range(0, 19) == 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      inst      = gen_inst();
      pc        = {$urandom(), $urandom()};
      regs[$urandom_range(1, 31)] = {$urandom(), $urandom()};
      exp_ready = !flush && (!m_valid || out_ready);
      #1;
      total++; if (in_ready !== exp_ready) begin bad++; $display("FAIL rnd_in_ready n=%0d got=%0b want=%0b", n, in_ready, exp_ready); end
      total++; if (rs1_addr !== inst[19:15] || rs2_addr !== inst[24:20]) begin
        bad++; $display("FAIL rnd_rs_addr n=%0d got=%0d/%0d want=%0d/%0d", n, rs1_addr, rs2_addr, inst[19:15], inst[24:20]); end
      total++; if (out_valid !== m_valid) begin bad++; $display("FAIL rnd_out_valid n=%0d got=%0b want=%0b", n, out_valid, m_valid); end
      if (m_valid) begin
        total++; if (op1 !== m_req.op1 || op2 !== m_req.op2 || ctr !== m_req.ctr) begin
          bad++; $display("FAIL rnd_alu n=%0d got %h/%h/%0d want %h/%h/%0d", n, op1, op2, ctr, m_req.op1, m_req.op2, m_req.ctr); end
        total++; if (wen !== m_req.wen || illegal !== m_req.ill || (!m_req.ill && rd !== m_req.rd)) begin
          bad++; $display("FAIL rnd_dest n=%0d got wen=%0b ill=%0b rd=%0d want %0b/%0b/%0d", n, wen, illegal, rd, m_req.wen, m_req.ill, m_req.rd); end
      end
      tick();
      if (rst || flush) m_valid = 1'b0;
      else if (in_valid && (!m_valid || out_ready)) begin
        m_valid = 1'b1;
        m_req   = ref_decode(inst, pc);
      end else if (out_ready) m_valid = 1'b0;
    end
    rst = 1'b0; idle_inputs();
  endtask

  initial begin
    for (int r = 0; r < 32; r++) regs[r] = (r == 0) ? 64'd0 : {$urandom(), $urandom()};
    test_reset();
    test_addi();
    test_lui();
    test_stall();
    test_back_to_back();
    test_flush_illegal();
    test_rst_mid_stall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
